// File: rtl/ro_meas_sched_pkg.sv
// Shared types and constants for the ring-oscillator measurement scheduler.
// Contents: FSM state enum, ARM/SETTLE phase lengths, result index width,
// and a lowest-set-bit index finder used for the RO visiting order.
`timescale 1ns/1ps
package ro_meas_sched_pkg;

    localparam int unsigned ARM_CYC    = 2;
    localparam int unsigned SETTLE_CYC = 4;
    localparam int unsigned IDX_W      = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        GATE    = 3'd2,
        SETTLE  = 3'd3,
        CAPTURE = 3'd4,
        REPORT  = 3'd5
    } state_t;

    // Index of the lowest set bit; 0 when the mask is empty.
    function automatic logic [IDX_W-1:0] lowest_idx(input logic [15:0] m);
        lowest_idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (m[i]) lowest_idx = IDX_W'(i);
        end
    endfunction

endpackage

// File: rtl/ro_meas_sched_edge_counter.sv
// Rising-edge counter clocked directly by one ring oscillator output.
// Ports: i_ro_clk (RO waveform used as clock), i_clr (async clear, active-high),
//        o_count (edge count), o_ovf (wrap / saturation flag).
// Config: RO_CNT_SAT_EN defined -> saturate at all-ones, flag set on reaching it;
//         undefined -> wrap modulo 2^CNT_W, flag sticky on first wrap.
`timescale 1ns/1ps
module ro_edge_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_ro_clk,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_count,
    output logic             o_ovf
);

    logic [CNT_W-1:0] r_count;
    logic             r_ovf;

    // Counts in the RO's own domain; the clk domain only reads it after it has stopped.
    always_ff @(posedge i_ro_clk or posedge i_clr) begin
        if (i_clr) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
`ifdef RO_CNT_SAT_EN
            if (!(&r_count)) begin
                r_count <= r_count + CNT_W'(1);
                if (r_count == ~CNT_W'(1)) r_ovf <= 1'b1;
            end
`else
            r_count <= r_count + CNT_W'(1);
            if (&r_count) r_ovf <= 1'b1;
`endif
        end
    end

    assign o_count = r_count;
    assign o_ovf   = r_ovf;

endmodule

// File: rtl/ro_meas_sched.sv
// Measurement scheduler for a bank of ring oscillators: visits each RO set in
// the mask (lowest index first), gates it for win_len clk cycles, lets it settle,
// captures its edge count through a 2-flop synchroniser and reports it on a
// valid/ready stream.
// Ports: clk, rst_n (async, active-high), start/abort controls, ro_mask and
//        win_len (sampled on accepted start), ro_out (raw RO waveforms),
//        ro_activate (one-hot-or-zero RO enables), res_valid/res_ready/res_idx/
//        res_count/res_ovf result stream, busy, done.
// Config: RO_CNT_SAT_EN selects saturating counters (see ro_edge_counter).
`timescale 1ns/1ps
module ro_meas_sched
    import ro_meas_sched_pkg::*;
#(
    parameter int unsigned NUM_RO = 4,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned WIN_W  = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [NUM_RO-1:0] ro_mask,
    input  logic [WIN_W-1:0]  win_len,
    input  logic [NUM_RO-1:0] ro_out,
    output logic [NUM_RO-1:0] ro_activate,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [IDX_W-1:0]  res_idx,
    output logic [CNT_W-1:0]  res_count,
    output logic              res_ovf,
    output logic              busy,
    output logic              done
);

    state_t            r_state;
    logic [NUM_RO-1:0] r_pend;
    logic [NUM_RO-1:0] r_oh;
    logic [IDX_W-1:0]  r_idx;
    logic [WIN_W-1:0]  r_win;
    logic [WIN_W-1:0]  r_tmr;
    logic [NUM_RO-1:0] r_clr;
    logic [NUM_RO-1:0] r_act;
    logic              r_res_valid;
    logic [IDX_W-1:0]  r_res_idx;
    logic [CNT_W-1:0]  r_res_count;
    logic              r_res_ovf;
    logic              r_busy;
    logic              r_done;
    logic [CNT_W:0]    r_sync1;
    logic [CNT_W:0]    r_sync2;

    logic [NUM_RO-1:0] w_first_oh;
    logic [IDX_W-1:0]  w_first_idx;
    logic [NUM_RO-1:0] w_next_oh;
    logic [IDX_W-1:0]  w_next_idx;
    logic [CNT_W-1:0]  w_cnt [NUM_RO];
    logic [NUM_RO-1:0] w_ovf;
    logic [NUM_RO-1:0] w_clr;
    logic [CNT_W:0]    w_sel;

    // Lowest set bit of the incoming mask and of the still-pending mask.
    assign w_first_oh  = ro_mask & (~ro_mask + NUM_RO'(1));
    assign w_first_idx = lowest_idx(16'(ro_mask));
    assign w_next_oh   = r_pend & (~r_pend + NUM_RO'(1));
    assign w_next_idx  = lowest_idx(16'(r_pend));

    // Reset also clears every counter so nothing stale survives a reset.
    assign w_clr = r_clr | {NUM_RO{rst_n}};

    for (genvar g = 0; g < NUM_RO; g++) begin : g_cnt
        ro_edge_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .i_ro_clk (ro_out[g]),
            .i_clr    (w_clr[g]),
            .o_count  (w_cnt[g]),
            .o_ovf    (w_ovf[g])
        );
    end

    // Select the counter of the RO currently being measured.
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NUM_RO; i++) begin
            if (r_oh[i]) w_sel = {w_ovf[i], w_cnt[i]};
        end
    end

    // Counter value is quiescent by CAPTURE; the two flops guard against metastability.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_sel;
            r_sync2 <= r_sync1;
        end
    end

    // Sweep FSM with registered outputs; abort has priority over everything.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state     <= IDLE;
            r_pend      <= '0;
            r_oh        <= '0;
            r_idx       <= '0;
            r_win       <= '0;
            r_tmr       <= '0;
            r_clr       <= '0;
            r_act       <= '0;
            r_res_valid <= 1'b0;
            r_res_idx   <= '0;
            r_res_count <= '0;
            r_res_ovf   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (abort && (r_state != IDLE)) begin
                r_state     <= IDLE;
                r_act       <= '0;
                r_clr       <= '0;
                r_pend      <= '0;
                r_res_valid <= 1'b0;
                r_busy      <= 1'b0;
                r_done      <= 1'b1;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (start) begin
                            if (ro_mask != '0) begin
                                r_oh    <= w_first_oh;
                                r_idx   <= w_first_idx;
                                r_pend  <= ro_mask & ~w_first_oh;
                                r_win   <= (win_len == '0) ? WIN_W'(1) : win_len;
                                r_tmr   <= WIN_W'(ARM_CYC - 1);
                                r_clr   <= w_first_oh;
                                r_busy  <= 1'b1;
                                r_state <= ARM;
                            end else begin
                                r_done <= 1'b1;
                            end
                        end
                    end
                    ARM: begin
                        if (r_tmr == '0) begin
                            r_clr   <= '0;
                            r_act   <= r_oh;
                            r_tmr   <= r_win - WIN_W'(1);
                            r_state <= GATE;
                        end else begin
                            r_tmr <= r_tmr - WIN_W'(1);
                        end
                    end
                    GATE: begin
                        if (r_tmr == '0) begin
                            r_act   <= '0;
                            r_tmr   <= WIN_W'(SETTLE_CYC - 1);
                            r_state <= SETTLE;
                        end else begin
                            r_tmr <= r_tmr - WIN_W'(1);
                        end
                    end
                    SETTLE: begin
                        if (r_tmr == '0) begin
                            r_state <= CAPTURE;
                        end else begin
                            r_tmr <= r_tmr - WIN_W'(1);
                        end
                    end
                    CAPTURE: begin
                        r_res_idx   <= r_idx;
                        r_res_count <= r_sync2[CNT_W-1:0];
                        r_res_ovf   <= r_sync2[CNT_W];
                        r_res_valid <= 1'b1;
                        r_state     <= REPORT;
                    end
                    REPORT: begin
                        if (res_ready) begin
                            r_res_valid <= 1'b0;
                            if (r_pend != '0) begin
                                r_oh    <= w_next_oh;
                                r_idx   <= w_next_idx;
                                r_pend  <= r_pend & ~w_next_oh;
                                r_tmr   <= WIN_W'(ARM_CYC - 1);
                                r_clr   <= w_next_oh;
                                r_state <= ARM;
                            end else begin
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= IDLE;
                            end
                        end
                    end
                    default: begin
                        r_act   <= '0;
                        r_clr   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign ro_activate = r_act;
    assign res_valid   = r_res_valid;
    assign res_idx     = r_res_idx;
    assign res_count   = r_res_count;
    assign res_ovf     = r_res_ovf;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule
